// File: rtl/sram_arb_pkg.sv
// ============================================================================
// Package  : sram_arb_pkg
// Brief    : State encodings, requester indices and defaults for the SRAM arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package sram_arb_pkg;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] ACK   = 3'd3;
    localparam logic [2:0] ABORT = 3'd4;

    localparam int REQ_SLV_WR = 0;
    localparam int REQ_SLV_RD = 1;
    localparam int REQ_MST_WR = 2;
    localparam int REQ_MST_RD = 3;

    localparam int TIMEOUT_DEFAULT = 64;

endpackage

`default_nettype wire

// File: rtl/sram_port_arbiter_rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Brief    : Rotating priority encoder: first eligible index at or above rr_ptr.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_pick
    import sram_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int SELW = 2
) (
    input  logic [NREQ-1:0] eligible_i,
    input  logic [SELW-1:0] rr_ptr_i,
    output logic            valid_o,
    output logic [SELW-1:0] idx_o
);

    logic [SELW-1:0] w_cand;

    // Index wrap relies on NREQ == 2**SELW, so the add overflows modulo NREQ.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        w_cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_cand = rr_ptr_i + SELW'(i);
            if (!valid_o && eligible_i[w_cand]) begin
                valid_o = 1'b1;
                idx_o   = w_cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sram_port_arbiter.sv
// ============================================================================
// Module   : sram_port_arbiter
// Brief    : Round-robin arbiter/sequencer for the shared SRAM port.
//            SRAM_ARB_TIMEOUT_EN adds an op_done watchdog and timeout_err_o.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int SELW    = 2,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_i,
    input  logic [NREQ-1:0] ok_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [NREQ-1:0] ack_o,
    output logic            op_start_o,
    output logic [SELW-1:0] op_sel_o,
    input  logic            op_done_i,
    output logic            busy_o
`ifdef SRAM_ARB_TIMEOUT_EN
    ,
    output logic            timeout_err_o
`endif
);

    logic [2:0]      state_q, state_d;
    logic [SELW-1:0] op_sel_q, op_sel_d;
    logic [SELW-1:0] rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            op_start_q, op_start_d;
    logic            busy_q, busy_d;

    logic            w_pick_valid;
    logic [SELW-1:0] w_pick_idx;
    logic            w_expired;

    rr_pick #(
        .NREQ (NREQ),
        .SELW (SELW)
    ) u_rr_pick (
        .eligible_i (req_i & ok_i),
        .rr_ptr_i   (rr_ptr_q),
        .valid_o    (w_pick_valid),
        .idx_o      (w_pick_idx)
    );

`ifdef SRAM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_err_q, timeout_err_d;

    // Counter is zero on entry to START, so START plus WAIT spans TIMEOUT cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == START || state_q == WAIT) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = '0;
        end
        w_expired     = (cnt_q == CW'(TIMEOUT - 1));
        timeout_err_d = timeout_err_q | (state_d == ABORT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err_o = timeout_err_q;
`else
    assign w_expired = 1'b0;
`endif

    // State register, including the registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_sel_q   <= '0;
            rr_ptr_q   <= '0;
            gnt_q      <= '0;
            ack_q      <= '0;
            op_start_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_sel_q   <= op_sel_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_q      <= gnt_d;
            ack_q      <= ack_d;
            op_start_q <= op_start_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        op_sel_d = op_sel_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (w_pick_valid) begin
                    state_d  = START;
                    op_sel_d = w_pick_idx;
                end
            end
            START, WAIT: begin
                if (op_done_i) begin
                    state_d = ACK;
                end else if (w_expired) begin
                    state_d = ABORT;
                end else begin
                    state_d = WAIT;
                end
            end
            ACK, ABORT: begin
                rr_ptr_d = op_sel_q + SELW'(1);
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from the next state so they appear registered in that state.
    always_comb begin
        gnt_d      = '0;
        ack_d      = '0;
        op_start_d = (state_d == START);
        busy_d     = (state_d != IDLE);
        if (state_d == START || state_d == WAIT || state_d == ACK) begin
            gnt_d[op_sel_d] = 1'b1;
        end
        if (state_d == ACK) begin
            ack_d[op_sel_d] = 1'b1;
        end
    end

    assign gnt_o      = gnt_q;
    assign ack_o      = ack_q;
    assign op_start_o = op_start_q;
    assign op_sel_o   = op_sel_q;
    assign busy_o     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
// ============================================================================
// Module   : tb_sram_port_arbiter
// Brief    : Directed, table-driven bench for sram_port_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sram_port_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] ok;
    logic [3:0] gnt;
    logic [3:0] ack;
    logic       op_start;
    logic [1:0] op_sel;
    logic       op_done;
    logic       busy;
`ifdef SRAM_ARB_TIMEOUT_EN
    logic       timeout_err;
`endif

    int checks   = 0;
    int failures = 0;

`ifdef SRAM_ARB_TIMEOUT_EN
    sram_port_arbiter #(.NREQ(4), .SELW(2), .TIMEOUT(8)) dut (
`else
    sram_port_arbiter #(.NREQ(4), .SELW(2)) dut (
`endif
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req),
        .ok_i       (ok),
        .gnt_o      (gnt),
        .ack_o      (ack),
        .op_start_o (op_start),
        .op_sel_o   (op_sel),
        .op_done_i  (op_done),
        .busy_o     (busy)
`ifdef SRAM_ARB_TIMEOUT_EN
        ,
        .timeout_err_o (timeout_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] ok;
        logic       done;
        logic [3:0] gnt;
        logic [3:0] ack;
        logic       start;
        logic [1:0] sel;
        logic       busy;
    } vec_t;

    vec_t tbl[27];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string name, input logic [3:0] g, input logic [3:0] a,
                            input logic s, input logic [1:0] sl, input logic b);
        chk({name, ".gnt"},   32'(gnt),      32'(g));
        chk({name, ".ack"},   32'(ack),      32'(a));
        chk({name, ".start"}, 32'(op_start), 32'(s));
        chk({name, ".sel"},   32'(op_sel),   32'(sl));
        chk({name, ".busy"},  32'(busy),     32'(b));
    endtask

    task automatic do_reset();
        req     = 4'b0000;
        ok      = 4'b0000;
        op_done = 1'b0;
        rst_n   = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(input logic done, input logic [3:0] g, input logic [3:0] a,
                                input logic s, input logic [1:0] sl, input logic b);
        vec_t v;
        v.req   = 4'b1111;
        v.ok    = 4'b1111;
        v.done  = done;
        v.gnt   = g;
        v.ack   = a;
        v.start = s;
        v.sel   = sl;
        v.busy  = b;
        return v;
    endfunction

    initial begin
        int n;
        logic [3:0] oh;

        // Round robin, op_done one cycle after each op_start: START, WAIT, ACK, IDLE.
        for (int k = 0; k < 5; k++) begin
            oh = 4'b0001 << (k % 4);
            tbl[4*k+0] = mk(1'b0, oh,    4'b0000, 1'b1, 2'(k % 4), 1'b1);
            tbl[4*k+1] = mk(1'b0, oh,    4'b0000, 1'b0, 2'(k % 4), 1'b1);
            tbl[4*k+2] = mk(1'b1, oh,    oh,      1'b0, 2'(k % 4), 1'b1);
            tbl[4*k+3] = mk(1'b0, 4'b0,  4'b0000, 1'b0, 2'(k % 4), 1'b0);
        end
        // op_done sampled in START skips WAIT; op_done in ACK and IDLE is ignored.
        tbl[20] = mk(1'b0, 4'b0010, 4'b0000, 1'b1, 2'd1, 1'b1);
        tbl[21] = mk(1'b1, 4'b0010, 4'b0010, 1'b0, 2'd1, 1'b1);
        tbl[22] = mk(1'b1, 4'b0000, 4'b0000, 1'b0, 2'd1, 1'b0);
        tbl[23] = mk(1'b1, 4'b0100, 4'b0000, 1'b1, 2'd2, 1'b1);
        tbl[24] = mk(1'b0, 4'b0100, 4'b0000, 1'b0, 2'd2, 1'b1);
        tbl[25] = mk(1'b1, 4'b0100, 4'b0100, 1'b0, 2'd2, 1'b1);
        tbl[26] = mk(1'b0, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0);

        // Reset held with all requests pending.
        rst_n   = 1'b0;
        req     = 4'b1111;
        ok      = 4'b1111;
        op_done = 1'b0;
        step();
        step();
        chk_outs("reset", 4'b0, 4'b0, 1'b0, 2'd0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 27; i++) begin
            req     = tbl[i].req;
            ok      = tbl[i].ok;
            op_done = tbl[i].done;
            step();
            chk_outs($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].ack, tbl[i].start,
                     tbl[i].sel, tbl[i].busy);
        end

        // Single request, op_done three cycles after op_start.
        do_reset();
        req = 4'b0100;
        ok  = 4'b0100;
        op_done = 1'b0;
        n = 0;
        step();
        chk_outs("single.start", 4'b0100, 4'b0, 1'b1, 2'd2, 1'b1);
        if (gnt == 4'b0100) n++;
        for (int i = 0; i < 3; i++) begin
            step();
            if (gnt == 4'b0100) n++;
            chk("single.noack", 32'(ack), 32'h0);
        end
        op_done = 1'b1;
        step();
        if (gnt == 4'b0100) n++;
        chk("single.ack", 32'(ack), 32'h4);
        chk("single.gnt_cycles", 32'(n), 32'd5);
        op_done = 1'b0;
        req = 4'b0000;
        step();
        chk_outs("single.idle", 4'b0, 4'b0, 1'b0, 2'd2, 1'b0);
        req = 4'b1111;
        ok  = 4'b1111;
        step();
        chk("single.next_rr", 32'(op_sel), 32'd3);
        op_done = 1'b1;
        step();
        chk("single.fast_ack", 32'(ack), 32'h8);
        req = 4'b0000;
        op_done = 1'b0;
        step();

        // Qualifier gating.
        req = 4'b1000;
        ok  = 4'b0000;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (op_start || busy) n++;
        end
        chk("gate.blocked", 32'(n), 32'd0);
        ok = 4'b1000;
        step();
        chk("gate.start", 32'(op_start), 32'd1);
        chk("gate.sel", 32'(op_sel), 32'd3);
        op_done = 1'b1;
        step();
        req = 4'b0000;
        ok  = 4'b0000;
        op_done = 1'b0;
        step();

        // Request withdrawn mid-access still gets its ack.
        req = 4'b0010;
        ok  = 4'b0010;
        step();
        chk("mid.start_sel", 32'(op_sel), 32'd1);
        step();
        req = 4'b0000;
        ok  = 4'b0000;
        step();
        chk("mid.gnt_held", 32'(gnt), 32'h2);
        op_done = 1'b1;
        step();
        chk("mid.ack", 32'(ack), 32'h2);
        op_done = 1'b0;
        step();

        // Asynchronous reset during WAIT.
        req = 4'b1111;
        ok  = 4'b1111;
        step();
        chk("rst.pre_sel", 32'(op_sel), 32'd2);
        step();
        chk("rst.pre_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outs("rst.async", 4'b0, 4'b0, 1'b0, 2'd0, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        chk_outs("rst.rr_zero", 4'b0001, 4'b0, 1'b1, 2'd0, 1'b1);
        op_done = 1'b1;
        step();
        req = 4'b0000;
        op_done = 1'b0;
        step();

`ifdef SRAM_ARB_TIMEOUT_EN
        // Engine never answers: abort after TIMEOUT cycles.
        do_reset();
        chk("to.err_reset", 32'(timeout_err), 32'd0);
        req = 4'b0001;
        ok  = 4'b0001;
        step();
        chk("to.start", 32'(op_start), 32'd1);
        n = 0;
        for (int i = 0; i < 7; i++) begin
            step();
            if (!busy || ack != 4'b0 || timeout_err) n++;
        end
        chk("to.waiting", 32'(n), 32'd0);
        step();
        chk("to.err", 32'(timeout_err), 32'd1);
        chk("to.noack", 32'(ack), 32'h0);
        chk("to.abort_busy", 32'(busy), 32'd1);
        req = 4'b0011;
        ok  = 4'b0011;
        step();
        chk("to.idle", 32'(busy), 32'd0);
        step();
        chk("to.next_sel", 32'(op_sel), 32'd1);
        chk("to.err_sticky", 32'(timeout_err), 32'd1);
`else
        // Without the watchdog, WAIT holds indefinitely.
        do_reset();
        req = 4'b0001;
        ok  = 4'b0001;
        step();
        n = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (!busy || gnt != 4'b0001 || ack != 4'b0) n++;
        end
        chk("nowd.wait_forever", 32'(n), 32'd0);
        op_done = 1'b1;
        step();
        chk("nowd.ack", 32'(ack), 32'h1);
        op_done = 1'b0;
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
